// File: rtl/rib_pkg.sv
// Shared types for the RIB bus arbiter: transfer size codes, bus owner and FSM state.
package rib_pkg;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  typedef enum logic [1:0] {
    OWN_M0   = 2'd0,
    OWN_M1   = 2'd1,
    OWN_M2   = 2'd2,
    OWN_NONE = 2'd3
  } owner_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rib_prio_pick.sv
// Fixed-priority pick M0 > M1 > M2; a starving M2 is promoted above M1 only.
module rib_prio_pick
  import rib_pkg::*;
(
  input  logic [2:0] req,
  input  logic       starve,
  output owner_e     winner
);

  always_comb begin
    winner = OWN_NONE;
    if (req[0])                winner = OWN_M0;
    else if (req[2] && starve) winner = OWN_M2;
    else if (req[1])           winner = OWN_M1;
    else if (req[2])           winner = OWN_M2;
  end

endmodule

// File: rtl/rib_arbiter.sv
// Three-master arbiter in front of one bus slave port, with M2 anti-starvation and response timeout.
module rib_arbiter
  import rib_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  input  logic [2:0]    m0_size_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic [2:0]    m1_size_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [DW-1:0] m1_rdata_o,
  input  logic          m2_req_i,
  input  logic          m2_we_i,
  input  logic [AW-1:0] m2_addr_i,
  input  logic [DW-1:0] m2_wdata_i,
  input  logic [2:0]    m2_size_i,
  output logic          m2_ack_o,
  output logic          m2_err_o,
  output logic [DW-1:0] m2_rdata_o,
  output logic          s_req_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_wdata_o,
  output logic [2:0]    s_size_o,
  input  logic          s_ack_i,
  input  logic [DW-1:0] s_rdata_i,
  output logic          hold_flag_o,
  output logic [1:0]    grant_o
);

  localparam int unsigned CNT_MAX = (STARVE_LIMIT > TIMEOUT) ? STARVE_LIMIT : TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_e        state;
  owner_e        owner;
  owner_e        pick;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] tmo_cnt;
  logic          starve;
  logic          done_ok;
  logic          done_tmo;
  logic [2:0]    ack_vec;
  logic [DW-1:0] rdata;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [2:0]    sel_size;

  assign starve = (starve_cnt == CW'(STARVE_LIMIT));

  rib_prio_pick u_pick (
    .req    ({m2_req_i, m1_req_i, m0_req_i}),
    .starve (starve),
    .winner (pick)
  );

  // Request payload of the IDLE-cycle winner, captured on grant
  always_comb begin
    sel_we    = m2_we_i;
    sel_addr  = m2_addr_i;
    sel_wdata = m2_wdata_i;
    sel_size  = m2_size_i;
    if (pick == OWN_M0) begin
      sel_we    = m0_we_i;
      sel_addr  = m0_addr_i;
      sel_wdata = m0_wdata_i;
      sel_size  = m0_size_i;
    end else if (pick == OWN_M1) begin
      sel_we    = m1_we_i;
      sel_addr  = m1_addr_i;
      sel_wdata = m1_wdata_i;
      sel_size  = m1_size_i;
    end
  end

  // Completion is taken straight from the slave ack (or timeout) while BUSY
  assign done_ok  = (state == BUSY) && s_ack_i;
  assign done_tmo = (state == BUSY) && !s_ack_i && (tmo_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    ack_vec = 3'b000;
    if (done_ok || done_tmo) begin
      case (owner)
        OWN_M0:  ack_vec = 3'b001;
        OWN_M1:  ack_vec = 3'b010;
        OWN_M2:  ack_vec = 3'b100;
        default: ack_vec = 3'b000;
      endcase
    end
  end

  assign rdata = (done_ok && !s_we_o) ? s_rdata_i : '0;

  assign m0_ack_o   = ack_vec[0];
  assign m1_ack_o   = ack_vec[1];
  assign m2_ack_o   = ack_vec[2];
  assign m0_err_o   = ack_vec[0] && done_tmo;
  assign m1_err_o   = ack_vec[1] && done_tmo;
  assign m2_err_o   = ack_vec[2] && done_tmo;
  assign m0_rdata_o = ack_vec[0] ? rdata : '0;
  assign m1_rdata_o = ack_vec[1] ? rdata : '0;
  assign m2_rdata_o = ack_vec[2] ? rdata : '0;

  assign hold_flag_o = (m0_req_i && !m0_ack_o) || (m1_req_i && !m1_ack_o);
  assign grant_o     = owner;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      tmo_cnt   <= '0;
      s_req_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      s_size_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (pick != OWN_NONE) begin
            state     <= BUSY;
            owner     <= pick;
            s_req_o   <= 1'b1;
            s_we_o    <= sel_we;
            s_addr_o  <= sel_addr;
            s_wdata_o <= sel_wdata;
            s_size_o  <= sel_size;
          end
        end
        BUSY: begin
          if (done_ok || done_tmo) begin
            state   <= IDLE;
            owner   <= OWN_NONE;
            s_req_o <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // M2 wait counter: saturates at the promotion threshold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!m2_req_i || owner == OWN_M2 || (state == IDLE && pick == OWN_M2)) begin
      starve_cnt <= '0;
    end else if (!starve) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule
